// File: rtl/arm_run_controller_if.sv
// Control bundle between the run controller and the ARM pipeline:
// halt/step requests in, reset/enable/status out.
interface arm_run_controller_if #(
    parameter int CNT_W = 16
);
    logic             halt_req;
    logic             step_req;
    logic             core_rst;
    logic             core_en;
    logic             running;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        input  halt_req, step_req,
        output core_rst, core_en, running, done, timeout, cycle_count
    );

    modport slave (
        output halt_req, step_req,
        input  core_rst, core_en, running, done, timeout, cycle_count
    );
endinterface

// File: rtl/arm_run_controller.sv
// Stretches the external reset into core_rst, gates the pipeline with core_en,
// counts enabled cycles and halts on a WB halt request or on the cycle budget.
module arm_run_controller #(
    parameter int RST_HOLD    = 4,
    parameter int CYCLE_LIMIT = 250,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    arm_run_controller_if.master   bus
);
    localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HW-1:0]    HOLD_LAST = HW'(RST_HOLD - 1);
    localparam bit               LIMIT_EN  = (CYCLE_LIMIT != 0);
    localparam logic [CNT_W-1:0] LIMIT_M1  = LIMIT_EN ? CNT_W'(CYCLE_LIMIT - 1) : '0;

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2,
        STEP   = 2'd3
    } state_t;

    state_t           state_q;
    logic [HW-1:0]    hold_cnt_q;
    logic [CNT_W-1:0] cycle_count_q;
    logic [CNT_W-1:0] cycle_count_d;
    logic             core_rst_q, core_en_q, running_q, done_q, timeout_q;

    // Saturating increment: with no budget the counter pins at all-ones.
    always_comb begin
        cycle_count_d = cycle_count_q;
        if (!(&cycle_count_q)) cycle_count_d = cycle_count_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= HOLD;
            hold_cnt_q    <= '0;
            cycle_count_q <= '0;
            core_rst_q    <= 1'b1;
            core_en_q     <= 1'b0;
            running_q     <= 1'b0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            case (state_q)
                HOLD: begin
                    core_rst_q <= 1'b1;
                    core_en_q  <= 1'b0;
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_q    <= RUN;
                        core_rst_q <= 1'b0;
                        core_en_q  <= 1'b1;
                        running_q  <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HW'(1);
                    end
                end
                RUN: begin
                    cycle_count_q <= cycle_count_d;
                    // Halt has priority over the budget on the same edge.
                    if (bus.halt_req || (LIMIT_EN && cycle_count_q == LIMIT_M1)) begin
                        state_q   <= HALTED;
                        core_en_q <= 1'b0;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                        timeout_q <= !bus.halt_req;
                    end
                end
                HALTED: begin
                    if (bus.step_req) begin
                        state_q   <= STEP;
                        core_en_q <= 1'b1;
                    end
                end
                STEP: begin
                    cycle_count_q <= cycle_count_d;
                    state_q       <= HALTED;
                    core_en_q     <= 1'b0;
                end
                default: begin
                    state_q    <= HOLD;
                    hold_cnt_q <= '0;
                    core_rst_q <= 1'b1;
                    core_en_q  <= 1'b0;
                    running_q  <= 1'b0;
                    done_q     <= 1'b0;
                    timeout_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.core_rst    = core_rst_q;
    assign bus.core_en     = core_en_q;
    assign bus.running     = running_q;
    assign bus.done        = done_q;
    assign bus.timeout     = timeout_q;
    assign bus.cycle_count = cycle_count_q;
endmodule

// File: tb/tb_arm_run_controller.sv
// Bench for arm_run_controller: three instances (budget 10, budget 250, no budget
// with a 4-bit counter) share stimulus and are checked against a cycle model.
module tb_arm_run_controller;
    localparam int RH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    arm_run_controller_if #(.CNT_W(16)) ifa ();
    arm_run_controller_if #(.CNT_W(16)) ifb ();
    arm_run_controller_if #(.CNT_W(4))  ifc ();

    arm_run_controller #(.RST_HOLD(RH), .CYCLE_LIMIT(10),  .CNT_W(16)) u_a (.clk(clk), .rst(rst), .bus(ifa.master));
    arm_run_controller #(.RST_HOLD(RH), .CYCLE_LIMIT(250), .CNT_W(16)) u_b (.clk(clk), .rst(rst), .bus(ifb.master));
    arm_run_controller #(.RST_HOLD(RH), .CYCLE_LIMIT(0),   .CNT_W(4))  u_c (.clk(clk), .rst(rst), .bus(ifc.master));

    logic halt_req = 1'b0;
    logic step_req = 1'b0;
    assign ifa.halt_req = halt_req;  assign ifa.step_req = step_req;
    assign ifb.halt_req = halt_req;  assign ifb.step_req = step_req;
    assign ifc.halt_req = halt_req;  assign ifc.step_req = step_req;

    // Flags packed as {core_rst, core_en, running, done, timeout}.
    logic [4:0]  d_fl  [3];
    logic [15:0] d_cnt [3];
    assign d_fl[0]  = {ifa.core_rst, ifa.core_en, ifa.running, ifa.done, ifa.timeout};
    assign d_fl[1]  = {ifb.core_rst, ifb.core_en, ifb.running, ifb.done, ifb.timeout};
    assign d_fl[2]  = {ifc.core_rst, ifc.core_en, ifc.running, ifc.done, ifc.timeout};
    assign d_cnt[0] = ifa.cycle_count;
    assign d_cnt[1] = ifb.cycle_count;
    assign d_cnt[2] = {12'd0, ifc.cycle_count};

    int ntot = 0;
    int npass = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Behavioural model: cycles of hold remaining, halted/stepping flags, count.
    int LIM  [3] = '{10, 250, 0};
    int CMAX [3] = '{65535, 65535, 15};
    int m_hold [3];
    bit m_halt [3];
    bit m_step [3];
    bit m_to   [3];
    int m_cnt  [3];
    bit mvalid = 0;

    function automatic logic [4:0] exp_flags(input int i);
        bit live;
        live = (m_hold[i] == 0);
        return {!live, live && (m_step[i] || !m_halt[i]), live && !m_halt[i] && !m_step[i],
                live && (m_halt[i] || m_step[i]), m_to[i]};
    endfunction

    task automatic wait_cnt(input int inst, input int val, input int budget, input string nm);
        int n;
        n = 0;
        while (d_cnt[inst] != 16'(val) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, d_cnt[inst], val);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; halt_req = 1'b0; step_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_step();
        @(negedge clk); step_req = 1'b1;
        @(negedge clk); step_req = 1'b0;
    endtask

    initial begin
        fork
            forever begin
                logic r, h, s;
                @(posedge clk);
                r = rst; h = halt_req; s = step_req;
                #1;
                for (int i = 0; i < 3; i++) begin
                    if (r) begin
                        m_hold[i] = RH; m_halt[i] = 0; m_step[i] = 0; m_cnt[i] = 0; m_to[i] = 0;
                    end else if (m_hold[i] > 0) begin
                        m_hold[i]--;
                    end else if (m_step[i]) begin
                        m_step[i] = 0;
                        if (m_cnt[i] < CMAX[i]) m_cnt[i]++;
                    end else if (m_halt[i]) begin
                        if (s) m_step[i] = 1;
                    end else begin
                        if (m_cnt[i] < CMAX[i]) m_cnt[i]++;
                        if (h) begin m_halt[i] = 1; m_to[i] = 0; end
                        else if (LIM[i] != 0 && m_cnt[i] == LIM[i]) begin m_halt[i] = 1; m_to[i] = 1; end
                    end
                end
                if (r) mvalid = 1;
                if (mvalid)
                    for (int i = 0; i < 3; i++) begin
                        chk($sformatf("model inst%0d flags", i), d_fl[i], exp_flags(i));
                        chk($sformatf("model inst%0d count", i), d_cnt[i], m_cnt[i]);
                    end
            end
        join_none

        // Reset release: core_rst high for RH samples after release, then enable.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset core_rst", ifb.core_rst, 1);
        chk("reset core_en",  ifb.core_en, 0);
        chk("reset done",     ifb.done, 0);
        chk("reset count",    d_cnt[1], 0);
        for (int k = 1; k < RH; k++) begin
            @(negedge clk);
            chk($sformatf("hold core_rst %0d", k), ifb.core_rst, 1);
        end
        @(negedge clk);
        chk("release core_rst", ifb.core_rst, 0);
        chk("release core_en",  ifb.core_en, 1);
        chk("release count0",   d_cnt[1], 0);
        @(negedge clk);
        chk("release count1",   d_cnt[1], 1);

        // Halt request on the edge where count is 6.
        wait_cnt(1, 6, 20, "wait count6");
        halt_req = 1'b1;
        @(negedge clk); halt_req = 1'b0;
        chk("halt count",   d_cnt[1], 7);
        chk("halt timeout", ifb.timeout, 0);
        chk("halt running", ifb.running, 0);
        chk("halt done",    ifb.done, 1);

        // Single step: two isolated pulses, then a back-to-back pair.
        pulse_step();
        repeat (3) begin @(negedge clk); chk("step done", ifb.done, 1); end
        chk("step1 count", d_cnt[1], 8);
        pulse_step();
        repeat (3) begin @(negedge clk); chk("step done", ifb.done, 1); end
        chk("step2 count", d_cnt[1], 9);
        @(negedge clk); step_req = 1'b1;
        @(negedge clk); chk("step b2b done", ifb.done, 1);
        @(negedge clk); step_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("step b2b count", d_cnt[1], 10);
        chk("step b2b done2", ifb.done, 1);

        // Budget timeout on the limit-10 instance, held for 20 cycles.
        do_reset();
        wait_cnt(0, 10, 40, "wait budget");
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("budget count",   d_cnt[0], 10);
            chk("budget flags",   d_fl[0], 5'b00011);
        end

        // No budget: 4-bit counter saturates and keeps running.
        chk("sat count",   d_cnt[2], 15);
        chk("sat running", ifc.running, 1);

        // Reset mid-run at count 100.
        wait_cnt(1, 100, 200, "wait count100");
        rst = 1'b1;
        @(negedge clk);
        chk("midrst core_rst", ifb.core_rst, 1);
        chk("midrst count",    d_cnt[1], 0);
        chk("midrst done",     ifb.done, 0);
        rst = 1'b0;
        repeat (RH + 2) @(negedge clk);
        chk("midrst rerun", ifb.running, 1);

        // Halt and budget on the same edge: halt wins.
        do_reset();
        wait_cnt(0, 9, 40, "wait count9");
        halt_req = 1'b1;
        @(negedge clk); halt_req = 1'b0;
        chk("simul count",   d_cnt[0], 10);
        chk("simul done",    ifa.done, 1);
        chk("simul timeout", ifa.timeout, 0);

        // Randomised traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            rst      = ($urandom % 150) == 0;
            halt_req = ($urandom % 25) == 0;
            step_req = ($urandom % 4) == 0;
        end
        @(negedge clk);
        rst = 1'b0; halt_req = 1'b0; step_req = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
